button_gesture_detector: RTL

BUTTON_GESTURE_DETECTOR -- requirements
Module: button_gesture_detector

---
 rtl/button_gesture_detector_pkg.sv | 18 +
 rtl/button_gesture_detector.sv | 105 ++++++++++
 2 files changed

// File: rtl/button_gesture_detector_pkg.sv
// Shared button definitions: gesture FSM state encoding and ms-to-cycles
// conversion, used by the gesture detector and the debouncer.
package button_gesture_detector_pkg;

   typedef enum logic [2:0] {
      ST_IDLE      = 3'd0,
      ST_PRESS1    = 3'd1,
      ST_WAIT2     = 3'd2,
      ST_PRESS2    = 3'd3,
      ST_LONG_HELD = 3'd4
   } state_t;

   function automatic int unsigned ms_to_cycles(input int unsigned clk_freq,
                                                input int unsigned ms);
      return (clk_freq / 1000) * ms;
   endfunction

endpackage

// File: rtl/button_gesture_detector.sv
// Classifies debounced press/release pulses into single click, double click
// and long press; one shared state timer, all outputs registered.
module button_gesture_detector
   import button_gesture_detector_pkg::*;
#(
   parameter int unsigned CLK_FREQ        = 25_000_000,
   parameter int unsigned LONG_PRESS_MS   = 800,
   parameter int unsigned DOUBLE_CLICK_MS = 250
) (
   input  logic clk,
   input  logic rst_n,
   input  logic btn_pressed,
   input  logic btn_released,
   output logic single_click,
   output logic double_click,
   output logic long_press,
   output logic btn_held
);

   localparam int unsigned LONG_MAX = ms_to_cycles(CLK_FREQ, LONG_PRESS_MS);
   localparam int unsigned GAP_MAX  = ms_to_cycles(CLK_FREQ, DOUBLE_CLICK_MS);
   localparam int unsigned TMR_MAX  = (LONG_MAX > GAP_MAX) ? LONG_MAX : GAP_MAX;
   localparam int unsigned TMR_W    = (TMR_MAX > 0) ? $clog2(TMR_MAX + 1) : 1;

   localparam logic [TMR_W-1:0] LONG_T = TMR_W'(LONG_MAX);
   localparam logic [TMR_W-1:0] GAP_T  = TMR_W'(GAP_MAX);

   state_t           r_state;
   logic [TMR_W-1:0] r_timer;
   logic             r_single;
   logic             r_double;
   logic             r_long;
   logic             r_held;

   // A press coinciding with a release is treated as a release only.
   logic w_press_only;
   assign w_press_only = btn_pressed & ~btn_released;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state  <= ST_IDLE;
         r_timer  <= '0;
         r_single <= 1'b0;
         r_double <= 1'b0;
         r_long   <= 1'b0;
         r_held   <= 1'b0;
      end else begin
         r_single <= 1'b0;
         r_double <= 1'b0;
         r_long   <= 1'b0;
         // Saturating count; any transition below overrides with a clear.
         if (r_timer != '1) r_timer <= r_timer + 1'b1;
         case (r_state)
            ST_IDLE: begin
               if (w_press_only) begin
                  r_state <= ST_PRESS1;
                  r_timer <= '0;
                  r_held  <= 1'b1;
               end
            end
            ST_PRESS1: begin
               if (btn_released) begin
                  r_state <= ST_WAIT2;
                  r_timer <= '0;
                  r_held  <= 1'b0;
               end else if (r_timer == LONG_T) begin
                  r_state <= ST_LONG_HELD;
                  r_timer <= '0;
                  r_long  <= 1'b1;
               end
            end
            ST_WAIT2: begin
               if (w_press_only) begin
                  r_state  <= ST_PRESS2;
                  r_timer  <= '0;
                  r_double <= 1'b1;
                  r_held   <= 1'b1;
               end else if (r_timer == GAP_T) begin
                  r_state  <= ST_IDLE;
                  r_timer  <= '0;
                  r_single <= 1'b1;
               end
            end
            ST_PRESS2, ST_LONG_HELD: begin
               if (btn_released) begin
                  r_state <= ST_IDLE;
                  r_timer <= '0;
                  r_held  <= 1'b0;
               end
            end
            default: begin
               r_state <= ST_IDLE;
               r_timer <= '0;
               r_held  <= 1'b0;
            end
         endcase
      end
   end

   assign single_click = r_single;
   assign double_click = r_double;
   assign long_press   = r_long;
   assign btn_held     = r_held;

endmodule
